// File: rtl/btn_dbc_multi_if.sv
// Signal bundle between board buttons, the multi-channel debouncer and its consumers.
// The master side drives the enable and the raw/repeat-enable inputs; the slave is the debouncer.
interface btn_dbc_multi_if #(
  parameter int CHANNELS = 5
);
  logic                ena;
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] rep_en;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_press;
  logic [CHANNELS-1:0] btn_release;
  logic [CHANNELS-1:0] btn_repeat;
  logic [CHANNELS-1:0] btn_fire;

  modport master (
    output ena, btn_in, rep_en,
    input  btn_level, btn_press, btn_release, btn_repeat, btn_fire
  );

  modport slave (
    input  ena, btn_in, rep_en,
    output btn_level, btn_press, btn_release, btn_repeat, btn_fire
  );
endinterface

// File: rtl/btn_dbc_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, stable-count filter, press/release
// one-shots and a per-channel hold-to-repeat pulse generator.
module btn_dbc_multi #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 1000,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_RATE   = 10000
) (
  input logic             clk,
  input logic             rst,
  btn_dbc_multi_if.slave  bus
);

  localparam int FW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [FW-1:0] F_LAST = FW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  logic [CHANNELS-1:0] meta;
  logic [CHANNELS-1:0] sync;

  // NOTE: non-blocking assignments make the two stages shift together rather than collapse into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= bus.btn_in;
      sync <= meta;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [FW-1:0] fcnt;
    logic          level;
    logic          press;
    logic          rel;
    logic          differ;
    logic          flip;

    rep_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          rep_q, rep_nxt;

    assign differ = sync[i] ^ level;
    assign flip   = bus.ena && differ && (fcnt == F_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fcnt  <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= flip & ~level;
        rel   <= flip & level;
        if (!differ) begin
          fcnt <= '0;
        end else if (bus.ena) begin
          if (flip) begin
            fcnt  <= '0;
            level <= ~level;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
        rep_q <= rep_nxt;
      end
    end

    // A falling level wins over everything, so a repeat due on the release edge is dropped.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep_nxt   = 1'b0;
      if (bus.ena) begin
        if (flip && level) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else begin
          case (state)
            IDLE: begin
              if (flip) begin
                state_nxt = DELAY;
                rcnt_nxt  = '0;
              end
            end
            DELAY: begin
              if (!bus.rep_en[i]) begin
                rcnt_nxt = '0;
              end else if (rcnt == D_LAST) begin
                rep_nxt   = 1'b1;
                rcnt_nxt  = '0;
                state_nxt = REPEAT;
              end else begin
                rcnt_nxt = rcnt + RW'(1);
              end
            end
            REPEAT: begin
              if (!bus.rep_en[i]) begin
                rcnt_nxt  = '0;
                state_nxt = DELAY;
              end else if (rcnt == R_LAST) begin
                rep_nxt  = 1'b1;
                rcnt_nxt = '0;
              end else begin
                rcnt_nxt = rcnt + RW'(1);
              end
            end
            default: begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end
          endcase
        end
      end
    end

    assign bus.btn_level[i]   = level;
    assign bus.btn_press[i]   = press;
    assign bus.btn_release[i] = rel;
    assign bus.btn_repeat[i]  = rep_q;
    assign bus.btn_fire[i]    = press | rep_q;
  end

endmodule

// File: tb/tb_btn_dbc_multi.sv
// Directed bench for btn_dbc_multi with 4 channels, 4-cycle filter, repeat delay 10, rate 3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_btn_dbc_multi;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   presses;
  bit   rep_exp;

  btn_dbc_multi_if #(.CHANNELS(CH)) bus ();

  btn_dbc_multi #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_RATE   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    bus.ena    = 1'b1;
    bus.btn_in = '0;
    bus.rep_en = '0;
    step(2);
    check("reset level",   bus.btn_level,   0);
    check("reset press",   bus.btn_press,   0);
    check("reset release", bus.btn_release, 0);
    check("reset repeat",  bus.btn_repeat,  0);
    check("reset fire",    bus.btn_fire,    0);
    rst = 1'b1;
    step(2);

    // Clean press and release on ch0
    bus.btn_in = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("t1 level e%0d", k), bus.btn_level, (k >= 6) ? 32'h1 : 32'h0);
      check($sformatf("t1 press e%0d", k), bus.btn_press, (k == 6) ? 32'h1 : 32'h0);
      check($sformatf("t1 fire e%0d", k),  bus.btn_fire,  (k == 6) ? 32'h1 : 32'h0);
    end
    bus.btn_in = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t1 release e%0d", k), bus.btn_release, (k == 6) ? 32'h1 : 32'h0);
      check($sformatf("t1 rlevel e%0d", k),  bus.btn_level,   (k < 6) ? 32'h1 : 32'h0);
    end

    // Bounce on ch1: 3 high / 2 low, three times, then steady high
    for (int r = 0; r < 3; r++) begin
      bus.btn_in[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        check("t2 bounce press", bus.btn_press, 0);
        check("t2 bounce level", bus.btn_level, 0);
      end
      bus.btn_in[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        step();
        check("t2 bounce press", bus.btn_press, 0);
        check("t2 bounce level", bus.btn_level, 0);
      end
    end
    bus.btn_in[1] = 1'b1;
    presses = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.btn_press[1]) presses++;
      check($sformatf("t2 press e%0d", k), bus.btn_press, (k == 6) ? 32'h2 : 32'h0);
      check($sformatf("t2 level e%0d", k), bus.btn_level, (k >= 6) ? 32'h2 : 32'h0);
    end
    check("t2 press count", presses, 1);
    bus.btn_in[1] = 1'b0;
    step(8);
    check("t2 released", bus.btn_level, 0);

    // Hold ch2 with auto-repeat; release timed so the fall lands on a would-be repeat cycle
    bus.rep_en = 4'b0100;
    bus.btn_in = 4'b0100;
    step(6);
    for (int c = 0; c <= 40; c++) begin
      rep_exp = (c >= 10) && (c < 37) && ((c - 10) % 3 == 0);
      check($sformatf("t3 repeat c%0d", c),  bus.btn_repeat[2],  rep_exp);
      check($sformatf("t3 fire c%0d", c),    bus.btn_fire[2],    (c == 0) || rep_exp);
      check($sformatf("t3 press c%0d", c),   bus.btn_press[2],   c == 0);
      check($sformatf("t3 release c%0d", c), bus.btn_release[2], c == 37);
      check($sformatf("t3 level c%0d", c),   bus.btn_level[2],   c < 37);
      if (c == 31) bus.btn_in[2] = 1'b0;
      step();
    end

    // ena gap of 5 cycles on ch3 while its filter count is 2
    bus.rep_en = 4'b0000;
    bus.btn_in = 4'b1000;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("t4 level e%0d", k), bus.btn_level, (k >= 11) ? 32'h8 : 32'h0);
      check($sformatf("t4 press e%0d", k), bus.btn_press, (k == 11) ? 32'h8 : 32'h0);
      if (k == 4) bus.ena = 1'b0;
      if (k == 9) bus.ena = 1'b1;
    end

    // Asynchronous reset while ch0 repeats, then behaviour as from power-up
    bus.rep_en = 4'b0001;
    bus.btn_in = 4'b0001;
    step(6);
    check("t5 press c0", bus.btn_press[0], 1'b1);
    step(13);
    check("t5 repeat c13", bus.btn_repeat[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t5 async level",   bus.btn_level,   0);
    check("t5 async press",   bus.btn_press,   0);
    check("t5 async release", bus.btn_release, 0);
    check("t5 async repeat",  bus.btn_repeat,  0);
    check("t5 async fire",    bus.btn_fire,    0);
    step(2);
    check("t5 held level", bus.btn_level, 0);
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check($sformatf("t5 press e%0d", k),  bus.btn_press[0],  k == 6);
      check($sformatf("t5 repeat e%0d", k), bus.btn_repeat[0], k == 16);
      check($sformatf("t5 level e%0d", k),  bus.btn_level[0],  k >= 6);
    end

    // rep_en on ch1 dropped at cycle 5, raised again at cycle 12
    bus.btn_in = 4'b0000;
    bus.rep_en = 4'b0000;
    step(8);
    check("t6 idle level", bus.btn_level, 0);
    bus.btn_in = 4'b0010;
    bus.rep_en = 4'b0010;
    step(6);
    for (int c = 0; c <= 26; c++) begin
      check($sformatf("t6 press c%0d", c),  bus.btn_press[1],  c == 0);
      check($sformatf("t6 repeat c%0d", c), bus.btn_repeat[1], (c == 22) || (c == 25));
      if (c == 5)  bus.rep_en[1] = 1'b0;
      if (c == 12) bus.rep_en[1] = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
